// File: rtl/dma_rd_arbiter.sv
// Two-to-one AXI4 read arbiter: round-robin AR grant with a registered issue stage,
// combinational R routing by RID, per-requester outstanding-burst throttling and a sticky fault flag.
module dma_rd_arbiter #(
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_DATA_W      = 64,
  parameter int AXI_ID_W        = 4,
  parameter int S0_ID           = 0,
  parameter int S1_ID           = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [AXI_ID_W-1:0]   s0_axi_arid,
  input  logic [AXI_ADDR_W-1:0] s0_axi_araddr,
  input  logic [7:0]            s0_axi_arlen,
  input  logic [2:0]            s0_axi_arsize,
  input  logic [1:0]            s0_axi_arburst,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [AXI_ID_W-1:0]   s0_axi_rid,
  output logic [AXI_DATA_W-1:0] s0_axi_rdata,
  output logic [1:0]            s0_axi_rresp,
  output logic                  s0_axi_rlast,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  input  logic [AXI_ID_W-1:0]   s1_axi_arid,
  input  logic [AXI_ADDR_W-1:0] s1_axi_araddr,
  input  logic [7:0]            s1_axi_arlen,
  input  logic [2:0]            s1_axi_arsize,
  input  logic [1:0]            s1_axi_arburst,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [AXI_ID_W-1:0]   s1_axi_rid,
  output logic [AXI_DATA_W-1:0] s1_axi_rdata,
  output logic [1:0]            s1_axi_rresp,
  output logic                  s1_axi_rlast,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  output logic [AXI_ID_W-1:0]   m_axi_arid,
  output logic [AXI_ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_ID_W-1:0]   m_axi_rid,
  input  logic [AXI_DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic                  err_clr,
  output logic                  rid_err,
  output logic                  busy
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {AR_IDLE, AR_ISSUE} ar_state_t;

  ar_state_t             state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic [AXI_ID_W-1:0]   arid_q, arid_d;
  logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic                  rid_err_q, rid_err_d;

  logic [1:0] req_valid, rready_in, eligible, rmatch, inc, dec, cnt_nz, cnt_fault;
  logic       grant, ar_accept, ar_done, ar_fault, r_fault;

  assign req_valid = {s1_axi_arvalid, s0_axi_arvalid};
  assign rready_in = {s1_axi_rready, s0_axi_rready};
  assign rmatch[0] = (m_axi_rid == AXI_ID_W'(S0_ID));
  assign rmatch[1] = (m_axi_rid == AXI_ID_W'(S1_ID));
  assign ar_done   = (state_q == AR_ISSUE) && m_axi_arready;

  // Per-requester outstanding-burst counter; a completing burst and a newly issued one cancel out.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign eligible[gi] = req_valid[gi] && (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign inc[gi]      = ar_done && (owner_q == 1'(gi));
    assign dec[gi]      = m_axi_rvalid && rmatch[gi] && rready_in[gi] && m_axi_rlast;
    assign cnt_nz[gi]   = (cnt_q != '0);

    always_comb begin
      cnt_d         = cnt_q;
      cnt_fault[gi] = dec[gi] && (cnt_q == '0);
      if (inc[gi] && !dec[gi]) begin
        cnt_d = cnt_q + 1'b1;
      end else if (dec[gi] && !inc[gi] && (cnt_q != '0)) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end

  assign grant          = (eligible == 2'b11) ? ~last_grant_q : eligible[1];
  assign s0_axi_arready = (state_q == AR_IDLE) && !grant && eligible[0];
  assign s1_axi_arready = (state_q == AR_IDLE) &&  grant && eligible[1];
  assign ar_accept      = s0_axi_arready || s1_axi_arready;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    ar_fault     = 1'b0;
    case (state_q)
      AR_IDLE: begin
        if (ar_accept) begin
          state_d      = AR_ISSUE;
          owner_d      = grant;
          last_grant_d = grant;
          arid_d       = grant ? s1_axi_arid    : s0_axi_arid;
          araddr_d     = grant ? s1_axi_araddr  : s0_axi_araddr;
          arlen_d      = grant ? s1_axi_arlen   : s0_axi_arlen;
          arsize_d     = grant ? s1_axi_arsize  : s0_axi_arsize;
          arburst_d    = grant ? s1_axi_arburst : s0_axi_arburst;
          ar_fault     = grant ? (s1_axi_arid != AXI_ID_W'(S1_ID))
                               : (s0_axi_arid != AXI_ID_W'(S0_ID));
        end
      end
      AR_ISSUE: begin
        if (m_axi_arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  // Beats with an unknown RID are drained so the interconnect never stalls on them.
  assign r_fault      = m_axi_rvalid && !(|rmatch);
  assign m_axi_rready = rmatch[0] ? s0_axi_rready : (rmatch[1] ? s1_axi_rready : 1'b1);

  always_comb begin
    rid_err_d = rid_err_q;
    if (ar_fault || r_fault || (|cnt_fault)) rid_err_d = 1'b1;
    else if (err_clr)                        rid_err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= AR_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      rid_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      rid_err_q    <= rid_err_d;
    end
  end

  assign m_axi_arvalid = (state_q == AR_ISSUE);
  assign m_axi_arid    = arid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = arsize_q;
  assign m_axi_arburst = arburst_q;

  assign s0_axi_rid    = m_axi_rid;
  assign s0_axi_rdata  = m_axi_rdata;
  assign s0_axi_rresp  = m_axi_rresp;
  assign s0_axi_rlast  = m_axi_rlast;
  assign s0_axi_rvalid = m_axi_rvalid && rmatch[0];
  assign s1_axi_rid    = m_axi_rid;
  assign s1_axi_rdata  = m_axi_rdata;
  assign s1_axi_rresp  = m_axi_rresp;
  assign s1_axi_rlast  = m_axi_rlast;
  assign s1_axi_rvalid = m_axi_rvalid && rmatch[1];

  assign rid_err = rid_err_q;
  assign busy    = (state_q == AR_ISSUE) || (|cnt_nz);

endmodule

// File: tb/tb_dma_rd_arbiter.sv
// Bench for dma_rd_arbiter: AR scoreboard plus an outstanding-count model,
// with directed scenarios for contention, throttling, R routing, faults and reset.
module tb_dma_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  s0_axi_arid, s1_axi_arid, m_axi_arid;
  logic [31:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
  logic [7:0]  s0_axi_arlen, s1_axi_arlen, m_axi_arlen;
  logic [2:0]  s0_axi_arsize, s1_axi_arsize, m_axi_arsize;
  logic [1:0]  s0_axi_arburst, s1_axi_arburst, m_axi_arburst;
  logic        s0_axi_arvalid, s1_axi_arvalid, s0_axi_arready, s1_axi_arready;
  logic [3:0]  s0_axi_rid, s1_axi_rid, m_axi_rid;
  logic [63:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
  logic [1:0]  s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
  logic        s0_axi_rlast, s1_axi_rlast, m_axi_rlast;
  logic        s0_axi_rvalid, s1_axi_rvalid, m_axi_rvalid;
  logic        s0_axi_rready, s1_axi_rready, m_axi_rready;
  logic        m_axi_arvalid, m_axi_arready;
  logic        err_clr, rid_err, busy;

  always #5 clk = ~clk;

  dma_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axi_arid(s0_axi_arid), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arlen(s0_axi_arlen),
    .s0_axi_arsize(s0_axi_arsize), .s0_axi_arburst(s0_axi_arburst),
    .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
    .s0_axi_rid(s0_axi_rid), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rlast(s0_axi_rlast), .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_arid(s1_axi_arid), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arlen(s1_axi_arlen),
    .s1_axi_arsize(s1_axi_arsize), .s1_axi_arburst(s1_axi_arburst),
    .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
    .s1_axi_rid(s1_axi_rid), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rlast(s1_axi_rlast), .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .err_clr(err_clr), .rid_err(rid_err), .busy(busy)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        owner;
  } ar_rec_t;

  typedef struct {
    logic port;
    int   cyc;
  } gnt_t;

  ar_rec_t exp_q[$];
  gnt_t    glog[$];
  ar_rec_t mon_rec, mon_exp;
  int      total = 0;
  int      bad = 0;
  int      cyc_n = 0;
  int      mdl_cnt[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: samples late in the low phase, after stimulus has settled and before the rising edge.
  always begin
    @(negedge clk);
    #3;
    cyc_n++;
    if (!rst_n) begin
      exp_q.delete();
      mdl_cnt[0] = 0;
      mdl_cnt[1] = 0;
    end else begin
      chk("busy", busy, (exp_q.size() != 0) || (mdl_cnt[0] != 0) || (mdl_cnt[1] != 0));
      chk("m_arvalid", m_axi_arvalid, exp_q.size() != 0);
      chk("ar_onehot", s0_axi_arready & s1_axi_arready, 0);
      if (m_axi_rvalid) begin
        logic exp_rdy;
        exp_rdy = (m_axi_rid == 4'd0) ? s0_axi_rready :
                  (m_axi_rid == 4'd1) ? s1_axi_rready : 1'b1;
        chk("r0_valid", s0_axi_rvalid, m_axi_rid == 4'd0);
        chk("r1_valid", s1_axi_rvalid, m_axi_rid == 4'd1);
        chk("m_rready", m_axi_rready, exp_rdy);
        chk("r0_data", s0_axi_rdata, m_axi_rdata);
        chk("r1_data", s1_axi_rdata, m_axi_rdata);
        chk("r1_resp", s1_axi_rresp, m_axi_rresp);
        if (exp_rdy && m_axi_rlast && (m_axi_rid < 4'd2) && (mdl_cnt[m_axi_rid] > 0))
          mdl_cnt[m_axi_rid]--;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          chk("m_arid", m_axi_arid, mon_exp.id);
          chk("m_araddr", m_axi_araddr, mon_exp.addr);
          chk("m_arlen", m_axi_arlen, mon_exp.len);
          chk("m_arsize", m_axi_arsize, mon_exp.size);
          chk("m_arburst", m_axi_arburst, mon_exp.burst);
          mdl_cnt[mon_exp.owner]++;
        end
      end
      if (s0_axi_arvalid && s0_axi_arready) begin
        mon_rec = '{s0_axi_arid, s0_axi_araddr, s0_axi_arlen, s0_axi_arsize, s0_axi_arburst, 1'b0};
        exp_q.push_back(mon_rec);
        glog.push_back('{1'b0, cyc_n});
      end
      if (s1_axi_arvalid && s1_axi_arready) begin
        mon_rec = '{s1_axi_arid, s1_axi_araddr, s1_axi_arlen, s1_axi_arsize, s1_axi_arburst, 1'b1};
        exp_q.push_back(mon_rec);
        glog.push_back('{1'b1, cyc_n});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic last, input logic [63:0] d);
    @(negedge clk);
    m_axi_rvalid = 1'b1;
    m_axi_rid    = id;
    m_axi_rlast  = last;
    m_axi_rdata  = d;
    m_axi_rresp  = id[1:0];
  endtask

  task automatic r_idle();
    @(negedge clk);
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
  endtask

  task automatic wait_grant(input int n0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      #4;
      if (glog.size() > n0) ok = 1'b1;
    end
    chk("grant_timeout", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    s0_axi_arid = 4'd0; s0_axi_araddr = '0; s0_axi_arlen = '0; s0_axi_arsize = 3'd3;
    s0_axi_arburst = 2'd1; s0_axi_arvalid = 1'b0; s0_axi_rready = 1'b1;
    s1_axi_arid = 4'd1; s1_axi_araddr = '0; s1_axi_arlen = '0; s1_axi_arsize = 3'd3;
    s1_axi_arburst = 2'd1; s1_axi_arvalid = 1'b0; s1_axi_rready = 1'b1;
    m_axi_arready = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
    m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0; err_clr = 1'b0;
    mdl_cnt[0] = 0;
    mdl_cnt[1] = 0;

    // Reset values
    do_reset();
    #1;
    chk("rst_m_arvalid", m_axi_arvalid, 0);
    chk("rst_m_araddr", m_axi_araddr, 0);
    chk("rst_m_arid", m_axi_arid, 0);
    chk("rst_m_arlen", m_axi_arlen, 0);
    chk("rst_rid_err", rid_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s0_arready", s0_axi_arready, 0);
    chk("rst_s1_arready", s1_axi_arready, 0);

    // Single s1 request, then a 16-beat burst back
    @(negedge clk);
    s1_axi_araddr = 32'h1000_0080; s1_axi_arlen = 8'd15; s1_axi_arvalid = 1'b1;
    m_axi_arready = 1'b1;
    #1;
    chk("single_s1_arready", s1_axi_arready, 1);
    chk("single_s0_arready", s0_axi_arready, 0);
    @(negedge clk);
    s1_axi_arvalid = 1'b0;
    #1;
    chk("single_arready_pulse", s1_axi_arready, 0);
    chk("single_m_arvalid", m_axi_arvalid, 1);
    chk("single_m_araddr", m_axi_araddr, 32'h1000_0080);
    chk("single_m_arlen", m_axi_arlen, 15);
    chk("single_m_arid", m_axi_arid, 1);
    @(negedge clk);
    #1;
    chk("single_arvalid_drop", m_axi_arvalid, 0);
    chk("single_busy", busy, 1);
    for (int i = 0; i < 16; i++) r_beat(4'd1, i == 15, 64'hA5A5_0000_0000_0000 + 64'(i));
    r_idle();
    #1;
    chk("single_busy_done", busy, 0);
    chk("single_no_err", rid_err, 0);

    // Contention from reset: expect 0,1,0,1 two cycles apart, then both throttled
    do_reset();
    glog.delete();
    @(negedge clk);
    s0_axi_arid = 4'd0; s0_axi_araddr = 32'h0000_4000; s0_axi_arlen = 8'd3; s0_axi_arvalid = 1'b1;
    s1_axi_arid = 4'd1; s1_axi_araddr = 32'h0000_8000; s1_axi_arlen = 8'd7; s1_axi_arvalid = 1'b1;
    m_axi_arready = 1'b1;
    repeat (10) @(negedge clk);
    #4;
    chk("cont_grants", glog.size(), 4);
    for (int i = 0; i < glog.size() && i < 4; i++) begin
      chk("cont_port", glog[i].port, i % 2);
      if (i > 0) chk("cont_gap", glog[i].cyc - glog[i-1].cyc, 2);
    end

    // Throttle: both at the limit, nothing accepted until an rlast frees a slot
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("thr_s0_blocked", s0_axi_arready, 0);
      chk("thr_s1_blocked", s1_axi_arready, 0);
    end
    n = glog.size();
    r_beat(4'd1, 1'b1, 64'h1111);
    r_idle();
    wait_grant(n);
    if (glog.size() > n) chk("thr_s1_regrant", glog[n].port, 1);
    r_beat(4'd0, 1'b1, 64'h2222);
    r_idle();
    wait_grant(n + 1);
    if (glog.size() > n + 1) chk("thr_s0_regrant", glog[n+1].port, 0);
    @(negedge clk);
    s0_axi_arvalid = 1'b0;
    s1_axi_arvalid = 1'b0;
    repeat (2) @(negedge clk);
    r_beat(4'd0, 1'b1, 64'h3333);
    r_beat(4'd0, 1'b1, 64'h4444);
    r_beat(4'd1, 1'b1, 64'h5555);
    r_beat(4'd1, 1'b1, 64'h6666);
    r_idle();
    #1;
    chk("thr_busy_done", busy, 0);
    chk("thr_no_err", rid_err, 0);

    // Interleaved R with s1 not ready
    s1_axi_rready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      r_beat(4'(i % 2), 1'b0, 64'hBEEF_0000 + 64'(i));
      #1;
      chk("il_r0_valid", s0_axi_rvalid, (i % 2) == 0);
      chk("il_r1_valid", s1_axi_rvalid, (i % 2) == 1);
      chk("il_m_rready", m_axi_rready, (i % 2) == 0);
    end
    r_idle();
    s1_axi_rready = 1'b1;

    // Faults: unknown RID, rlast with zero count, set-wins, ARID mismatch
    r_beat(4'd5, 1'b0, 64'hDEAD);
    #1;
    chk("unk_m_rready", m_axi_rready, 1);
    chk("unk_r0_valid", s0_axi_rvalid, 0);
    chk("unk_r1_valid", s1_axi_rvalid, 0);
    r_idle();
    #1;
    chk("unk_rid_err", rid_err, 1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1;
    chk("clr_rid_err", rid_err, 0);
    r_beat(4'd0, 1'b1, 64'h7777);
    r_idle();
    #1;
    chk("underflow_rid_err", rid_err, 1);
    chk("underflow_busy", busy, 0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1;
    chk("clr2_rid_err", rid_err, 0);
    r_beat(4'd5, 1'b0, 64'h8888);
    err_clr = 1'b1;
    r_idle();
    err_clr = 1'b0;
    #1;
    chk("set_wins_rid_err", rid_err, 1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    #1;
    chk("clr3_rid_err", rid_err, 0);
    @(negedge clk);
    s0_axi_arid = 4'd3; s0_axi_araddr = 32'h2000_0000; s0_axi_arlen = 8'd0; s0_axi_arvalid = 1'b1;
    n = glog.size();
    wait_grant(n);
    @(negedge clk);
    s0_axi_arvalid = 1'b0;
    s0_axi_arid = 4'd0;
    #1;
    chk("arid_bad_rid_err", rid_err, 1);
    r_beat(4'd0, 1'b1, 64'h9999);
    r_idle();
    #1;
    chk("arid_bad_busy", busy, 0);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;

    // Stall in AR_ISSUE with one burst outstanding, then asynchronous reset
    @(negedge clk);
    s1_axi_araddr = 32'h3000_0000; s1_axi_arlen = 8'd1; s1_axi_arvalid = 1'b1;
    n = glog.size();
    wait_grant(n);
    @(negedge clk);
    s1_axi_arvalid = 1'b0;
    @(negedge clk);
    m_axi_arready = 1'b0;
    s1_axi_araddr = 32'h3000_0040; s1_axi_arvalid = 1'b1;
    wait_grant(n + 1);
    @(negedge clk);
    s1_axi_arvalid = 1'b0;
    s0_axi_arvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("stall_m_arvalid", m_axi_arvalid, 1);
      chk("stall_m_araddr", m_axi_araddr, 32'h3000_0040);
      chk("stall_s0_arready", s0_axi_arready, 0);
      chk("stall_s1_arready", s1_axi_arready, 0);
    end
    @(negedge clk);
    s0_axi_arvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_m_arvalid", m_axi_arvalid, 0);
    chk("areset_busy", busy, 0);
    chk("areset_m_araddr", m_axi_araddr, 0);
    chk("areset_rid_err", rid_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_axi_arready = 1'b1;
    r_beat(4'd1, 1'b1, 64'hAAAA);
    r_idle();
    #1;
    chk("post_rst_rid_err", rid_err, 1);
    chk("post_rst_busy", busy, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_rd_arbiter.md
# dma_rd_arbiter

Two-to-one AXI4 read-channel arbiter that shares the single DDR read master port between the BSR weight DMA (requester 0, stream ID 0) and the activation DMA (requester 1, stream ID 1). The AR channel is granted round-robin and registered toward the interconnect. R beats are routed back combinationally by RID. The block tracks outstanding bursts per requester, throttles each requester at a configurable limit, and flags protocol faults in a sticky status bit for the CSR block.

## Interface
- AXI_ADDR_W, 32, address width
- AXI_DATA_W, 64, data width
- AXI_ID_W, 4, ID width
- S0_ID, 0, RID value owned by requester 0 (bsr_dma)
- S1_ID, 1, RID value owned by requester 1 (act_dma)
- MAX_OUTSTANDING, 2, max accepted-but-unfinished bursts per requester (≥1)

- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- sN_axi_arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  requester N AR fields (N=0,1)
- sN_axi_arvalid  in  1  requester N address valid
- sN_axi_arready  out  1  requester N address accepted
- sN_axi_rid/rdata/rresp/rlast  out  ID/DATA/2/1  requester N R fields (fanout of master R)
- sN_axi_rvalid  out  1  requester N data valid
- sN_axi_rready  in  1  requester N data ready
- m_axi_arid/araddr/arlen/arsize/arburst  out  ID/ADDR/8/3/2  master AR fields (registered)
- m_axi_arvalid  out  1  master address valid
- m_axi_arready  in  1  interconnect accept
- m_axi_rid/rdata/rresp/rlast/rvalid  in  ID/DATA/2/1/1  master R channel
- m_axi_rready  out  1  master data ready
- err_clr  in  1  clears rid_err
- rid_err  out  1  sticky protocol fault
- busy  out  1  AR issue pending or any burst outstanding

## Operation
- Requester N is eligible when sN_axi_arvalid=1 and out_cnt[N] < MAX_OUTSTANDING. Each out_cnt is $clog2(MAX_OUTSTANDING+1) bits wide.
- Arbitration uses a last_grant register, reset to 1 so requester 0 wins the first tie.
  - Both eligible: grant !last_grant.
  - One eligible: grant it.
- AR FSM, state AR_IDLE:
  - sN_axi_arready = (state==AR_IDLE && grant==N && eligible N). This is combinational and at most one is high.
  - On handshake: capture the five AR fields into the m_axi_ar* registers, record owner=N, set last_grant=N, and go to AR_ISSUE.
- AR FSM, state AR_ISSUE:
  - m_axi_arvalid=1 and the fields are held stable.
  - On m_axi_arready: drop arvalid, increment out_cnt[owner], and return to AR_IDLE.
- ARID is passed through unmodified. If a captured arid differs from the port's S*_ID, set rid_err. The request is still issued.
- R routing is combinational:
  - sN_axi_rvalid = m_axi_rvalid && (m_axi_rid==SN_ID).
  - R data fields fan out to both ports.
  - m_axi_rready = s0_axi_rready or s1_axi_rready of the matched port.
- Unmatched RID:
  - m_axi_rready=1, so the beat is drained.
  - No sN_axi_rvalid is asserted.
  - rid_err is set.
- A beat handshake with rlast=1 on port N decrements out_cnt[N].
  - If out_cnt[N] is already 0, set rid_err and hold the count at 0.
- Increment and decrement of the same counter in the same cycle leave it unchanged.
- rresp is forwarded untouched. Error handling stays in the DMAs.
- rid_err is set by any fault above and cleared by err_clr. If a fault and err_clr occur in the same cycle, set wins.
- busy = (state==AR_ISSUE) || out_cnt[0]!=0 || out_cnt[1]!=0. This is combinational.

## Timing
- Reset values:
  - state=AR_IDLE, last_grant=1, out_cnt=0.
  - m_axi_arvalid=0 and all m_axi_ar* fields = 0.
  - rid_err=0.
  - busy=0 and sN_axi_arready=0 when nothing is eligible.
- AR latency: the cycle after the sN handshake, m_axi_arvalid=1. The minimum requester-to-requester AR throughput is one grant per 2 cycles (accept cycle, then issue cycle with arready=1).
- A requester may drop arvalid before being granted; the arbiter does not latch un-accepted requests.
- R path has zero added latency; no R registers exist.
- Asserting rst_n low mid-burst returns everything to reset values immediately. Beats arriving after reset release are unmatched-by-count and raise rid_err only if rlast arrives with out_cnt=0.
- Master arready held low stalls the FSM in AR_ISSUE indefinitely. Both sN_axi_arready stay 0 during the stall.

## Test plan
- Single request: s1 arvalid, araddr=0x1000_0080, arlen=15, m_arready=1 → s1_arready pulses 1 cycle; next cycle m_arvalid=1 with araddr=0x1000_0080, arlen=15, arid=1; out_cnt[1]=1; after 16 R beats with rid=1 and last on beat 16, out_cnt[1]=0 and busy=0.
- Contention: s0 and s1 arvalid held continuously, m_arready=1 → grant order 0,1,0,1 from reset; each grant is 2 cycles apart.
- Throttle with MAX_OUTSTANDING=2: s0 issues 2 ARs and no R returns → third s0 request never gets arready while s1 is still granted; one rlast on rid=0 → s0 is accepted on the next arbitration.
- Interleaved R: beats with rid=0 and rid=1 alternate → only the matching sN_rvalid is high; s1_rready=0 stalls m_rready only on rid=1 beats.
- Faults: rid=5 beat arrives → m_rready=1, no sN_rvalid, rid_err=1; rlast on rid=0 with out_cnt[0]=0 → rid_err=1 and count stays 0; err_clr → rid_err=0.
- Reset mid-operation: rst_n low during AR_ISSUE with out_cnt[1]=1 → m_arvalid=0, busy=0, out_cnt cleared in the same cycle.
